// File: rtl/gpu_bg_reader.sv
// Background read-back unit: issues in-order VRAM word reads for pixel pairs and
// returns unpacked 5:5:5 left/right background colors plus mask bits in request order.
module gpu_bg_reader #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [9:0]  i_reqX,
    input  logic [8:0]  i_reqY,
    input  logic        i_reqNeedBG,
    output logic        o_memReq,
    output logic [17:0] o_memAddr,
    input  logic        i_memAck,
    input  logic        i_memDataValid,
    input  logic [31:0] i_memData,
    output logic        o_bgValid,
    input  logic        i_bgReady,
    output logic [4:0]  o_rBG_L,
    output logic [4:0]  o_gBG_L,
    output logic [4:0]  o_bgB_L,
    output logic [4:0]  o_rBG_R,
    output logic [4:0]  o_gBG_R,
    output logic [4:0]  o_bBG_R,
    output logic        o_mskL,
    output logic        o_mskR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] out_cnt;
    logic          busy;
    logic [17:0]   addr;

    // Order FIFO occupancy equals cnt, so it needs no wrap bit of its own.
    logic          ord_mem [DEPTH];
    logic [AW-1:0] ord_wp;
    logic [AW-1:0] ord_rp;

    logic [31:0]   dat_mem [DEPTH];
    logic [AW:0]   dat_wp;
    logic [AW:0]   dat_rp;

    logic          accept;
    logic          pop;
    logic          mem_ack;
    logic          data_push;
    logic          head_need;
    logic          dat_empty;
    logic [31:0]   pix;

    assign o_reqReady = (cnt < FULL) && !busy;
    assign accept     = i_reqValid && o_reqReady;
    assign mem_ack    = busy && i_memAck;
    // Returns with nothing outstanding are stray and must not enter the data FIFO.
    assign data_push  = i_memDataValid && (out_cnt != '0);

    assign head_need  = ord_mem[ord_rp];
    assign dat_empty  = (dat_wp == dat_rp);
    assign o_bgValid  = (cnt != '0) && (!head_need || !dat_empty);
    assign pop        = o_bgValid && i_bgReady;

    assign o_memReq   = busy;
    assign o_memAddr  = addr;

    assign pix     = (o_bgValid && head_need) ? dat_mem[dat_rp[AW-1:0]] : '0;
    assign o_rBG_L = pix[4:0];
    assign o_gBG_L = pix[9:5];
    assign o_bgB_L = pix[14:10];
    assign o_mskL  = pix[15];
    assign o_rBG_R = pix[20:16];
    assign o_gBG_R = pix[25:21];
    assign o_bBG_R = pix[30:26];
    assign o_mskR  = pix[31];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt     <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            addr    <= '0;
            ord_wp  <= '0;
            ord_rp  <= '0;
            dat_wp  <= '0;
            dat_rp  <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            case ({mem_ack, data_push})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase

            if (accept && i_reqNeedBG) begin
                busy <= 1'b1;
                addr <= {i_reqY, i_reqX[9:1]};
            end else if (mem_ack) begin
                busy <= 1'b0;
            end

            if (accept)    ord_wp <= ord_wp + 1'b1;
            if (pop)       ord_rp <= ord_rp + 1'b1;
            if (data_push) dat_wp <= dat_wp + 1'b1;
            if (pop && head_need) dat_rp <= dat_rp + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; clearing the pointers already makes every
    // entry unreachable, and leaving arrays unreset lets them map to plain RAM.
    always_ff @(posedge clk) begin
        if (accept)    ord_mem[ord_wp] <= i_reqNeedBG;
        if (data_push) dat_mem[dat_wp[AW-1:0]] <= i_memData;
    end

endmodule

// File: tb/tb_gpu_bg_reader.sv
// Self-checking bench for gpu_bg_reader: table-driven single transactions plus
// directed ordering, backpressure, randomized wrap and mid-operation reset sequences.
module tb_gpu_bg_reader;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [9:0]  i_reqX;
    logic [8:0]  i_reqY;
    logic        i_reqNeedBG;
    logic        o_memReq;
    logic [17:0] o_memAddr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic        o_bgValid;
    logic        i_bgReady;
    logic [4:0]  o_rBG_L, o_gBG_L, o_bgB_L, o_rBG_R, o_gBG_R, o_bBG_R;
    logic        o_mskL, o_mskR;

    int n_checks = 0;
    int n_bad    = 0;

    gpu_bg_reader #(.DEPTH(4)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_reqValid(i_reqValid), .o_reqReady(o_reqReady),
        .i_reqX(i_reqX), .i_reqY(i_reqY), .i_reqNeedBG(i_reqNeedBG),
        .o_memReq(o_memReq), .o_memAddr(o_memAddr), .i_memAck(i_memAck),
        .i_memDataValid(i_memDataValid), .i_memData(i_memData),
        .o_bgValid(o_bgValid), .i_bgReady(i_bgReady),
        .o_rBG_L(o_rBG_L), .o_gBG_L(o_gBG_L), .o_bgB_L(o_bgB_L),
        .o_rBG_R(o_rBG_R), .o_gBG_R(o_gBG_R), .o_bBG_R(o_bBG_R),
        .o_mskL(o_mskL), .o_mskR(o_mskR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic        need;
        logic [31:0] data;
        logic [17:0] exp_addr;
        logic [4:0]  rl, gl, bl;
        logic        ml;
        logic [4:0]  rr, gr, br;
        logic        mr;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bg_word();
        return {o_mskR, o_bBG_R, o_gBG_R, o_rBG_R, o_mskL, o_bgB_L, o_gBG_L, o_rBG_L};
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Presents one request and returns in the cycle after the accepting edge.
    task automatic send_req(input logic [9:0] x, input logic [8:0] y, input logic need);
        int n = 0;
        while (!o_reqReady && n < 50) begin
            tick();
            n++;
        end
        if (!o_reqReady) check("req_ready_wait", {31'd0, o_reqReady}, 32'd1);
        i_reqX = x;
        i_reqY = y;
        i_reqNeedBG = need;
        i_reqValid = 1'b1;
        tick();
        i_reqValid = 1'b0;
    endtask

    task automatic pop_one();
        i_bgReady = 1'b1;
        tick();
        i_bgReady = 1'b0;
    endtask

    task automatic return_data(input logic [31:0] d);
        i_memDataValid = 1'b1;
        i_memData = d;
        tick();
        i_memDataValid = 1'b0;
    endtask

    // Shared state for the randomized section.
    logic [17:0] addr_q [$];
    logic [31:0] exp_q  [$];
    int pending  = 0;
    int acc_cnt  = 0;
    int pop_cnt  = 0;
    int max_fly  = 0;

    initial begin
        i_rst = 1'b1;
        i_reqValid = 1'b0; i_reqX = '0; i_reqY = '0; i_reqNeedBG = 1'b0;
        i_memAck = 1'b0; i_memDataValid = 1'b0; i_memData = '0; i_bgReady = 1'b0;

        //                x       y       need  data           addr      rl  gl  bl  ml    rr  gr  br  mr
        vecs[0] = '{10'h0A3, 9'h1F0, 1'b1, 32'h8421_7FFF, 18'h3E051, 31, 31, 31, 1'b0, 1,  1,  1,  1'b1};
        vecs[1] = '{10'h000, 9'h000, 1'b1, 32'h0000_0000, 18'h00000, 0,  0,  0,  1'b0, 0,  0,  0,  1'b0};
        vecs[2] = '{10'h3FF, 9'h1FF, 1'b1, 32'h7C00_83E0, 18'h3FFFF, 0,  31, 0,  1'b1, 0,  0,  31, 1'b0};
        vecs[3] = '{10'h155, 9'h0AA, 1'b1, 32'h1234_5678, 18'h154AA, 24, 19, 21, 1'b0, 20, 17, 4,  1'b0};
        vecs[4] = '{10'h002, 9'h005, 1'b0, 32'hFFFF_FFFF, 18'h00000, 0,  0,  0,  1'b0, 0,  0,  0,  1'b0};

        do_reset();
        check("rst_req_ready", {31'd0, o_reqReady}, 32'd1);
        check("rst_mem_req",   {31'd0, o_memReq},   32'd0);
        check("rst_mem_addr",  {14'd0, o_memAddr},  32'd0);
        check("rst_bg_valid",  {31'd0, o_bgValid},  32'd0);
        check("rst_fields",    bg_word(),           32'd0);

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_w;
            exp_w = {vecs[i].mr, vecs[i].br, vecs[i].gr, vecs[i].rr,
                     vecs[i].ml, vecs[i].bl, vecs[i].gl, vecs[i].rl};
            send_req(vecs[i].x, vecs[i].y, vecs[i].need);
            if (vecs[i].need) begin
                check($sformatf("v%0d_mem_req", i), {31'd0, o_memReq}, 32'd1);
                check($sformatf("v%0d_addr", i), {14'd0, o_memAddr}, {14'd0, vecs[i].exp_addr});
                i_memAck = 1'b1;
                tick();
                i_memAck = 1'b0;
                check($sformatf("v%0d_req_drop", i), {31'd0, o_memReq}, 32'd0);
                tick();
                tick();
                check($sformatf("v%0d_not_early", i), {31'd0, o_bgValid}, 32'd0);
                return_data(vecs[i].data);
            end else begin
                check($sformatf("v%0d_no_mem_req", i), {31'd0, o_memReq}, 32'd0);
            end
            check($sformatf("v%0d_valid", i), {31'd0, o_bgValid}, 32'd1);
            check($sformatf("v%0d_fields", i), bg_word(), exp_w);
            pop_one();
            check($sformatf("v%0d_popped", i), {31'd0, o_bgValid}, 32'd0);
        end

        // Ordering: F1, Z, F2 must leave as D1, zero, D2.
        send_req(10'h002, 9'h001, 1'b1);
        check("ord_f1_addr", {14'd0, o_memAddr}, 32'h0000_0201);
        i_memAck = 1'b1; tick(); i_memAck = 1'b0;
        send_req(10'h004, 9'h001, 1'b0);
        check("ord_z_held", {31'd0, o_bgValid}, 32'd0);
        send_req(10'h006, 9'h001, 1'b1);
        check("ord_f2_addr", {14'd0, o_memAddr}, 32'h0000_0203);
        i_memAck = 1'b1; tick(); i_memAck = 1'b0;
        repeat (6) tick();
        check("ord_z_still_held", {31'd0, o_bgValid}, 32'd0);
        return_data(32'h1111_2222);
        check("ord_d1_valid", {31'd0, o_bgValid}, 32'd1);
        check("ord_d1", bg_word(), 32'h1111_2222);
        pop_one();
        check("ord_z_valid", {31'd0, o_bgValid}, 32'd1);
        check("ord_z", bg_word(), 32'd0);
        pop_one();
        check("ord_d2_wait", {31'd0, o_bgValid}, 32'd0);
        return_data(32'h3333_4444);
        check("ord_d2", bg_word(), 32'h3333_4444);
        pop_one();
        check("ord_empty", {31'd0, o_bgValid}, 32'd0);

        // Backpressure: six zero-BG requests with the consumer stalled.
        begin
            int accepts = 0;
            do_reset();
            i_reqNeedBG = 1'b0;
            i_reqValid = 1'b1;
            for (int c = 0; c < 6; c++) begin
                i_reqX = 10'(c * 2);
                if (o_reqReady) accepts++;
                tick();
            end
            i_reqValid = 1'b0;
            check("bp_accepts", accepts, 32'd4);
            check("bp_full_ready", {31'd0, o_reqReady}, 32'd0);
            check("bp_hold_valid", {31'd0, o_bgValid}, 32'd1);
            check("bp_hold_fields", bg_word(), 32'd0);
            pop_one();
            check("bp_ready_after_pop", {31'd0, o_reqReady}, 32'd1);
            check("bp_still_valid", {31'd0, o_bgValid}, 32'd1);
            i_bgReady = 1'b1;
            repeat (3) tick();
            i_bgReady = 1'b0;
            check("bp_drained", {31'd0, o_bgValid}, 32'd0);
        end

        // Randomized fetches across pointer wrap with concurrent accept and pop.
        fork
            begin : requester
                int sent = 0;
                int guard = 0;
                while (sent < 20 && guard < 3000) begin
                    logic [9:0] x;
                    logic [8:0] y;
                    x = 10'($urandom_range(0, 1023));
                    y = 9'($urandom_range(0, 511));
                    i_reqX = x;
                    i_reqY = y;
                    i_reqNeedBG = 1'b1;
                    i_reqValid = ($urandom_range(0, 2) != 0);
                    if (i_reqValid && o_reqReady) begin
                        addr_q.push_back({y, x[9:1]});
                        sent++;
                        acc_cnt++;
                        if (acc_cnt - pop_cnt > max_fly) max_fly = acc_cnt - pop_cnt;
                    end
                    tick();
                    guard++;
                end
                i_reqValid = 1'b0;
            end
            begin : acker
                int acked = 0;
                int guard = 0;
                while (acked < 20 && guard < 3000) begin
                    if (o_memReq && $urandom_range(0, 2) == 0) begin
                        if (addr_q.size() == 0) check("rand_addr_q", 32'd0, 32'd1);
                        else check("rand_addr", {14'd0, o_memAddr}, {14'd0, addr_q.pop_front()});
                        i_memAck = 1'b1;
                        tick();
                        i_memAck = 1'b0;
                        pending++;
                        acked++;
                    end else begin
                        tick();
                    end
                    guard++;
                end
            end
            begin : returner
                int ret = 0;
                int guard = 0;
                while (ret < 20 && guard < 3000) begin
                    if (pending > 0 && $urandom_range(0, 3) == 0) begin
                        logic [31:0] d;
                        d = $urandom();
                        exp_q.push_back(d);
                        i_memData = d;
                        i_memDataValid = 1'b1;
                        pending--;
                        ret++;
                    end else begin
                        i_memDataValid = 1'b0;
                    end
                    tick();
                    guard++;
                end
                i_memDataValid = 1'b0;
            end
            begin : consumer
                int guard = 0;
                while (pop_cnt < 20 && guard < 3000) begin
                    i_bgReady = ($urandom_range(0, 1) != 0);
                    if (o_bgValid && i_bgReady) begin
                        if (exp_q.size() == 0) check("rand_exp_q", 32'd0, 32'd1);
                        else check("rand_data", bg_word(), exp_q.pop_front());
                        pop_cnt++;
                    end
                    tick();
                    guard++;
                end
                i_bgReady = 1'b0;
            end
        join
        check("rand_all_popped", pop_cnt, 32'd20);
        check("rand_max_inflight_le4", {31'd0, (max_fly <= 4)}, 32'd1);

        // Stray return with nothing outstanding must produce no output.
        return_data(32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            check("stray_no_output", {31'd0, o_bgValid}, 32'd0);
            tick();
        end

        // Reset with two buffered entries and a fetch pending on the arbiter.
        send_req(10'h010, 9'h002, 1'b0);
        send_req(10'h012, 9'h002, 1'b0);
        send_req(10'h014, 9'h002, 1'b1);
        check("mid_mem_req", {31'd0, o_memReq}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mid_rst_mem_req", {31'd0, o_memReq}, 32'd0);
        check("mid_rst_valid", {31'd0, o_bgValid}, 32'd0);
        check("mid_rst_ready", {31'd0, o_reqReady}, 32'd1);
        send_req(10'h0A3, 9'h1F0, 1'b1);
        check("post_rst_addr", {14'd0, o_memAddr}, 32'h0003_E051);
        i_memAck = 1'b1; tick(); i_memAck = 1'b0;
        tick();
        return_data(32'h8421_7FFF);
        check("post_rst_data", bg_word(), 32'h8421_7FFF);
        pop_one();
        check("post_rst_empty", {31'd0, o_bgValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
